// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit counter BHT with tagged BTB, misprediction recovery and branch statistics
// Lookup is combinational from fetch; EX resolution trains one entry per cycle and drives the redirect.

module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [1:0]      ctr_q    [ENTRIES];
  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [31:0]     branch_count_q;
  logic [31:0]     mispredict_count_q;

  logic [IDX-1:0]  if_idx;
  logic [TAGW-1:0] if_tag;
  logic            if_hit;
  logic [IDX-1:0]  ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  logic            res;
  logic            target_wrong;
  logic [1:0]      ctr_d;
  logic            update_btb;
  logic [31:0]     branch_count_d;
  logic [31:0]     mispredict_count_d;

  // Word-offset bits of the PCs play no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[XLEN-1:IDX+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign pred_taken  = ~reset & if_valid & if_hit & ctr_q[if_idx][1];
  assign pred_target = (~reset & if_hit) ? target_q[if_idx] : '0;

  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign res          = ~reset & ex_valid & ex_is_branch & ~ex_stall;
  assign target_wrong = ex_taken & ex_pred_taken & (ex_target != ex_pred_target);
  assign mispredict   = res & ((ex_taken != ex_pred_taken) | target_wrong);
  assign redirect_pc  = ex_taken ? ex_target : (ex_pc + XLEN'(4));

  // A taken branch that misses the BTB claims the entry and starts weakly taken.
  always_comb begin
    ctr_d      = ctr_q[ex_idx];
    update_btb = 1'b0;
    if (ex_taken) begin
      update_btb = 1'b1;
      if (!ex_hit) begin
        ctr_d = 2'b10;
      end else if (ctr_q[ex_idx] != 2'b11) begin
        ctr_d = ctr_q[ex_idx] + 2'd1;
      end
    end else if (ctr_q[ex_idx] != 2'b00) begin
      ctr_d = ctr_q[ex_idx] - 2'd1;
    end
  end

  assign branch_count_d     = branch_count_q + 32'd1;
  assign mispredict_count_d = mispredict_count_q + {31'd0, mispredict};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= 2'b01;
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (res) begin
      ctr_q[ex_idx] <= ctr_d;
      if (update_btb) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
      end
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - scoreboard bench for branch_predictor_bht
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares them.

module tb_branch_predictor_bht;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            if_valid = 1'b0;
  logic [XLEN-1:0] if_pc = '0;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid = 1'b0;
  logic            ex_is_branch = 1'b0;
  logic            ex_stall = 1'b0;
  logic [XLEN-1:0] ex_pc = '0;
  logic            ex_taken = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            ex_pred_taken = 1'b0;
  logic [XLEN-1:0] ex_pred_target = '0;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  branch_predictor_bht #(.ENTRIES(64), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  localparam int S_PT = 0, S_TGT = 1, S_MIS = 2, S_RED = 3, S_BC = 4, S_MC = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_PT:    return {31'd0, pred_taken};
      S_TGT:   return pred_target;
      S_MIS:   return {31'd0, mispredict};
      S_RED:   return redirect_pc;
      S_BC:    return branch_count;
      default: return mispredict_count;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.sel);
        tests++;
        if (a !== e.exp) begin
          failed++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input logic [31:0] v);
    q.push_back('{name, sel, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
  endtask

  task automatic ex_br(input logic stall, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_stall       = stall;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_stall     = 1'b0;
  endtask

  task automatic counts(input string tag, input int bc, input int mc);
    expect_out({tag, "_bc"}, S_BC, bc);
    expect_out({tag, "_mc"}, S_MC, mc);
  endtask

  initial begin : stim
    // Reset held: outputs forced quiet even with a mispredicting EX.
    step();
    fetch(1, 32'h100);
    ex_br(0, 32'h100, 1, 32'h80, 0, 0);
    expect_out("rst_pt", S_PT, 0);
    expect_out("rst_mis", S_MIS, 0);
    counts("rst", 0, 0);

    step();
    reset = 1'b0;
    ex_idle();
    expect_out("init_pt", S_PT, 0);
    expect_out("init_tgt", S_TGT, 0);
    counts("init", 0, 0);

    // First taken branch; same-cycle fetch sees the pre-update entry.
    step();
    ex_br(0, 32'h100, 1, 32'h80, 0, 0);
    expect_out("t2_mis", S_MIS, 1);
    expect_out("t2_red", S_RED, 32'h80);
    expect_out("t2_nobypass_pt", S_PT, 0);
    step();
    ex_idle();
    expect_out("t2_pt", S_PT, 1);
    expect_out("t2_tgt", S_TGT, 32'h80);
    counts("t2", 1, 1);

    // Three correct taken: saturate at 11.
    for (int i = 0; i < 3; i++) begin
      step();
      ex_br(0, 32'h100, 1, 32'h80, 1, 32'h80);
      expect_out("t3_taken_mis", S_MIS, 0);
    end
    step();
    ex_idle();
    expect_out("t3_pt", S_PT, 1);
    counts("t3", 4, 1);

    step();
    ex_br(0, 32'h100, 0, 32'h80, 1, 32'h80);
    expect_out("t3_nt_mis", S_MIS, 1);
    expect_out("t3_nt_red", S_RED, 32'h104);
    step();
    ex_idle();
    expect_out("t3_ctr10_pt", S_PT, 1);
    counts("t3nt", 5, 2);

    step();
    ex_br(0, 32'h100, 0, 32'h80, 1, 32'h80);
    expect_out("t3_nt2_mis", S_MIS, 1);
    step();
    ex_idle();
    expect_out("t3_ctr01_pt", S_PT, 0);
    counts("t3nt2", 6, 3);

    // Drive to 00 and try to go below; a taken then reaches only 01.
    for (int i = 0; i < 2; i++) begin
      step();
      ex_br(0, 32'h100, 0, 32'h80, 0, 0);
      expect_out("lowsat_mis", S_MIS, 0);
    end
    step();
    ex_br(0, 32'h100, 1, 32'h80, 0, 0);
    expect_out("lowsat_tk_mis", S_MIS, 1);
    expect_out("lowsat_tk_red", S_RED, 32'h80);
    step();
    ex_idle();
    expect_out("lowsat_pt", S_PT, 0);
    expect_out("lowsat_tgt", S_TGT, 32'h80);
    counts("lowsat", 9, 4);

    // Alias 0x200 replaces the entry owned by 0x100.
    step();
    ex_br(0, 32'h200, 1, 32'h300, 0, 0);
    expect_out("t4_mis", S_MIS, 1);
    step();
    ex_idle();
    expect_out("t4_old_pt", S_PT, 0);
    expect_out("t4_old_tgt", S_TGT, 0);
    step();
    fetch(1, 32'h200);
    expect_out("t4_new_pt", S_PT, 1);
    expect_out("t4_new_tgt", S_TGT, 32'h300);
    counts("t4", 10, 5);

    // Right direction, wrong target.
    step();
    ex_br(0, 32'h200, 1, 32'h400, 1, 32'h300);
    expect_out("tgt_mis", S_MIS, 1);
    expect_out("tgt_red", S_RED, 32'h400);
    step();
    ex_idle();
    expect_out("tgt_new", S_TGT, 32'h400);
    counts("tgt", 11, 6);

    // Non-branch in EX.
    step();
    ex_br(0, 32'h200, 1, 32'h500, 0, 0);
    ex_is_branch = 1'b0;
    expect_out("nb_mis", S_MIS, 0);
    step();
    ex_idle();
    counts("nb", 11, 6);

    // Stalled mispredicting branch, then released.
    step();
    ex_br(1, 32'h200, 0, 0, 1, 32'h400);
    expect_out("stall_mis", S_MIS, 0);
    step();
    expect_out("stall2_mis", S_MIS, 0);
    expect_out("stall_pt", S_PT, 1);
    counts("stall", 11, 6);
    step();
    ex_stall = 1'b0;
    expect_out("unstall_mis", S_MIS, 1);
    expect_out("unstall_red", S_RED, 32'h204);
    step();
    ex_idle();
    counts("unstall", 12, 7);
    expect_out("unstall_pt", S_PT, 1);
    step();
    fetch(0, 32'h200);
    expect_out("ifinv_pt", S_PT, 0);
    expect_out("ifinv_tgt", S_TGT, 32'h400);

    // redirect wraps at the top of the address space.
    step();
    ex_br(0, 32'hFFFF_FFFC, 0, 0, 1, 32'h10);
    expect_out("wrap_mis", S_MIS, 1);
    expect_out("wrap_red", S_RED, 32'h0);
    step();
    ex_idle();
    counts("wrap", 13, 8);

    // Reset mid-operation.
    step();
    reset = 1'b1;
    fetch(1, 32'h200);
    ex_br(0, 32'h200, 0, 0, 1, 32'h400);
    expect_out("mrst_pt", S_PT, 0);
    expect_out("mrst_tgt", S_TGT, 0);
    expect_out("mrst_mis", S_MIS, 0);
    counts("mrst", 0, 0);
    step();
    reset = 1'b0;
    ex_idle();
    expect_out("post_pt", S_PT, 0);
    expect_out("post_tgt", S_TGT, 0);
    counts("post", 0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
